axi_lite_req_arbiter: RTL and testbench
=======================================

// Module: axi_lite_req_arbiter
// PURPOSE
//  Shares the single-outstanding rd/wr request port of the AXI-Lite master bridge between two requesters
//  (req0: PCIe BAR target path, req1: on-chip config/DMA engine). Round-robin grant, one transaction in flight,
//  drives level rd_en/wr_en that the bridge edge-detects, returns data/completion to the winner, times out hangs.
// PARAMETERS
//  TIMEOUT_CYCLES  1024          cycles in BUSY before forced error completion (>=4)
//  TO_W            11            timeout counter width; must hold TIMEOUT_CYCLES
//  ERR_RDATA       32'hDEADBEEF  read data returned on timeout
// PORTS
//  M_AXI_ACLK      in   1   clock
//  M_AXI_ARESET    in   1   reset, asynchronous, active-high
//  reqN_valid      in   1   (N=0,1) request pending; hold with fields stable until reqN_ready
//  reqN_we         in   1   1=write, 0=read
//  reqN_addr       in   32  dword address, [31:30]=BAR index (decoded by bridge)
//  reqN_be         in   4   byte enables
//  reqN_wdata      in   32  write data
//  reqN_ready      out  1   1-cycle accept pulse
//  reqN_done       out  1   1-cycle completion pulse
//  reqN_rdata      out  32  read data, valid with reqN_done (reads)
//  reqN_err        out  1   timeout flag, valid with reqN_done
//  rd_addr/rd_be   out  32/4 to bridge read port
//  rd_en           out  1   level, high through whole read
//  rd_data         in   32  from bridge
//  rd_data_valid   in   1   bridge read completion strobe
//  wr_addr/wr_be/wr_data out 32/4/32 to bridge write port
//  wr_en           out  1   level, high through whole write
//  wr_done         in   1   write completion strobe (M_AXI_BVALID & M_AXI_BREADY)
//  timeout_flag    out  1   sticky; set on any timeout, cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0 (rdata 0), state IDLE, last_grant=1 (req0 wins first), counter 0.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: if any valid: grant = only valid one, or !last_grant when both valid; latch we/addr/be/wdata into
//   bridge-side regs, pulse reqG_ready same cycle, last_grant<=G, counter<=0, -> BUSY. Else stay.
//  BUSY: rd_en (we=0) or wr_en (we=1) held 1; other enable 0. Counter increments each cycle.
//   Completion = rd_data_valid (read) or wr_done (write); the strobe of the other type is ignored.
//   On completion: capture rd_data, err<=0, -> DONE.
//   On counter==TIMEOUT_CYCLES-1 without completion: rdata<=ERR_RDATA, err<=1, timeout_flag<=1, -> DONE.
//   Completion and timeout in same cycle: completion wins, err=0.
//  DONE: rd_en=wr_en=0; pulse reqG_done with rdata/err for one cycle; -> IDLE.
//   Enables are low >=2 cycles (DONE+IDLE) between transactions so bridge edge-detect re-arms.
//  Latency: valid seen in IDLE -> ready same cycle, en high next cycle; done 1 cycle after completion strobe.
//  Back-to-back: requester may reassert valid the cycle after done; with both valid, grants alternate.
//  Completion strobes outside BUSY are ignored. After a timeout, bridge must be reset (late responses
//   are not filtered); timeout_flag reports this to software.
//  Reset mid-transaction: enables drop asynchronously, no done pulse issued, in-flight request lost.
//  reqN_rdata/err hold last values until next done for that requester.
// STRUCTURE
//  Shared package axi_lite_arb_pkg: FSM state encodings (IDLE/BUSY/DONE), ERR_RDATA default, requester index
//   constants. One sub-module natural: rr_arb2 (2-way round-robin, combinational grant + last_grant reg).
//  Top holds FSM, latch registers, timeout counter, output demux. Target 150-250 lines.
// TESTING
//  1 Reset release, req0 read addr 32'h4000_0010, bridge rd_data_valid 5 cycles later with 32'h1234_5678
//    -> req0_ready 1 cycle, rd_en high 6 cycles, req0_done with rdata 32'h1234_5678, err=0.
//  2 req0 and req1 valid same cycle (both writes) -> req0 granted first, req1 next; wr_en low >=2 cycles between.
//  3 req1 held valid continuously, req0 valid each IDLE -> grants alternate 1,0,1,0 (no starvation).
//  4 read with no response -> done after TIMEOUT_CYCLES, rdata 32'hDEADBEEF, err=1, timeout_flag stays 1.
//  5 wr_done during a read and rd_data_valid during IDLE -> both ignored, no spurious done.
//  6 assert M_AXI_ARESET while BUSY -> rd_en/wr_en 0 immediately, no done; next request completes normally.

Source files
------------

// File: rtl/axi_lite_arb_pkg.sv
// Shared constants for the AXI-Lite request arbiter: FSM encodings, requester
// indices, default error read word and the latched request record.
package axi_lite_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  // Lone requester wins; on contention the one not granted last time wins.
  function automatic logic rr_pick(input logic [1:0] valid, input logic last_grant);
    logic pick;
    if (valid == 2'b11) pick = ~last_grant;
    else                pick = valid[1];
    return pick;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, last-winner register
// updated only when the grant is actually taken.
module rr_arb2
  import axi_lite_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic       grant,
  output logic       any_valid
);

  logic last_grant;

  assign any_valid = |valid;
  assign grant     = rr_pick(valid, last_grant);

  // Reset to REQ1 so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= REQ1;
    end else if (accept) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/axi_lite_req_arbiter.sv
// Shares the single-outstanding rd/wr port of the AXI-Lite master bridge between
// two requesters: round-robin grant, one transaction in flight, hang timeout.
module axi_lite_req_arbiter
  import axi_lite_arb_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          TO_W           = 11,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESET,

  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [31:0] req0_addr,
  input  logic [3:0]  req0_be,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        req0_done,
  output logic [31:0] req0_rdata,
  output logic        req0_err,

  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [31:0] req1_addr,
  input  logic [3:0]  req1_be,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        req1_done,
  output logic [31:0] req1_rdata,
  output logic        req1_err,

  output logic [31:0] rd_addr,
  output logic [3:0]  rd_be,
  output logic        rd_en,
  input  logic [31:0] rd_data,
  input  logic        rd_data_valid,

  output logic [31:0] wr_addr,
  output logic [3:0]  wr_be,
  output logic [31:0] wr_data,
  output logic        wr_en,
  input  logic        wr_done,

  output logic        timeout_flag,
  output logic [1:0]  dbg_state
);

  // Handshake: reqN_valid is a level held with stable fields until the
  // one-cycle reqN_ready pulse; each accepted request gets exactly one
  // reqN_done pulse. The bridge sees level enables and answers with one strobe.

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]      state;
  req_t            cur;
  req_t            req_sel;
  logic            owner;
  logic [TO_W-1:0] to_cnt;

  logic            grant;
  logic            any_valid;
  logic            accept;
  logic            complete;
  logic            expire;
  logic            finish;
  logic [31:0]     result;

  rr_arb2 u_rr_arb2 (
    .clk       (M_AXI_ACLK),
    .rst       (M_AXI_ARESET),
    .valid     ({req1_valid, req0_valid}),
    .accept    (accept),
    .grant     (grant),
    .any_valid (any_valid)
  );

  assign accept  = (state == ST_IDLE) && any_valid;
  assign req_sel = (grant == REQ1)
                 ? '{we: req1_we, addr: req1_addr, be: req1_be, wdata: req1_wdata}
                 : '{we: req0_we, addr: req0_addr, be: req0_be, wdata: req0_wdata};

  // Only the strobe matching the in-flight direction counts as completion.
  assign complete = (state == ST_BUSY) && (cur.we ? wr_done : rd_data_valid);
  assign expire   = (state == ST_BUSY) && (to_cnt == TO_LAST) && !complete;
  assign finish   = complete || expire;
  assign result   = complete ? rd_data : ERR_RDATA;

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state  <= ST_IDLE;
      cur    <= '0;
      owner  <= REQ0;
      to_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state  <= ST_BUSY;
            cur    <= req_sel;
            owner  <= grant;
            to_cnt <= '0;
          end
        end
        ST_BUSY: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (finish) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Per-requester result registers hold until that requester's next completion.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      req0_rdata   <= '0;
      req0_err     <= 1'b0;
      req1_rdata   <= '0;
      req1_err     <= 1'b0;
      timeout_flag <= 1'b0;
    end else if (finish) begin
      if (owner == REQ0) begin
        req0_rdata <= result;
        req0_err   <= expire;
      end else begin
        req1_rdata <= result;
        req1_err   <= expire;
      end
      if (expire) timeout_flag <= 1'b1;
    end
  end

  assign req0_ready = accept && (grant == REQ0);
  assign req1_ready = accept && (grant == REQ1);
  assign req0_done  = (state == ST_DONE) && (owner == REQ0);
  assign req1_done  = (state == ST_DONE) && (owner == REQ1);

  // Enables decode straight from the state register so reset drops them at once.
  assign rd_en   = (state == ST_BUSY) && !cur.we;
  assign wr_en   = (state == ST_BUSY) &&  cur.we;
  assign rd_addr = cur.addr;
  assign rd_be   = cur.be;
  assign wr_addr = cur.addr;
  assign wr_be   = cur.be;
  assign wr_data = cur.wdata;

  assign dbg_state = state;

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Bench for axi_lite_req_arbiter: table-driven single transactions, hand-written
// contention/reset sequences and a randomized run against a transaction model.
module tb_axi_lite_req_arbiter;

  localparam int          T        = 20;
  localparam int          TW       = 5;
  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;
  localparam logic [7:0]  NEVER    = 8'hFF;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } rq_t;

  typedef struct packed {
    logic        who;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [7:0]  delay;
    logic [31:0] resp;
    logic        noise;
    logic [7:0]  exp_en;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        M_AXI_ACLK = 1'b0;
  logic        M_AXI_ARESET = 1'b1;
  logic        req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
  logic [31:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
  logic [3:0]  req0_be = 0, req1_be = 0;
  logic        req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err;
  logic [31:0] req0_rdata, req1_rdata;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic [3:0]  rd_be, wr_be;
  logic        rd_en, wr_en, timeout_flag;
  logic [31:0] rd_data = 0;
  logic        rd_data_valid = 0, wr_done = 0;
  logic [1:0]  dbg_state;

  axi_lite_req_arbiter #(.TIMEOUT_CYCLES(T), .TO_W(TW), .ERR_RDATA(ERR_WORD)) dut (
    .M_AXI_ACLK(M_AXI_ACLK), .M_AXI_ARESET(M_AXI_ARESET),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_be(req0_be),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_be(req1_be),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .rd_addr(rd_addr), .rd_be(rd_be), .rd_en(rd_en), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid),
    .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_en(wr_en), .wr_done(wr_done),
    .timeout_flag(timeout_flag), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 M_AXI_ACLK = ~M_AXI_ACLK;

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;

  rq_t         pend [2];
  logic        reissue [2];
  logic        gen_en, rand_delay, noise_en, idle_noise;
  logic [7:0]  plan_delay;
  logic [31:0] bus_rdata;

  // transaction-level reference: at most one request in flight, then one done cycle
  logic        m_busy, m_retire, m_owner, m_last, m_tflag;
  rq_t         m_cur;
  int          m_age;
  logic [31:0] m_rdata [2];
  logic        m_err [2];
  int          txn_count;

  logic        grant_exp_q [$];
  logic        rec_grants;
  int          obs_en, low_run;
  logic        seen_txn, obs_done, obs_who, obs_err;
  logic [31:0] obs_rdata;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic rq_t rand_req();
    rq_t r;
    r.valid = 1'b1;
    r.we    = 1'($urandom_range(0, 1));
    r.addr  = $urandom();
    r.be    = 4'($urandom_range(1, 15));
    r.wdata = $urandom();
    return r;
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_retire = 0; m_owner = 0; m_last = 1; m_tflag = 0; m_age = 0;
    m_cur = '0;
    m_rdata[0] = 0; m_rdata[1] = 0; m_err[0] = 0; m_err[1] = 0;
    seen_txn = 0; low_run = 0;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_inputs();
    logic hit;
    for (int i = 0; i < 2; i++)
      if (gen_en && !pend[i].valid && $urandom_range(0, 3) == 0) pend[i] = rand_req();
    {req0_valid, req0_we, req0_addr, req0_be, req0_wdata} = pend[0];
    {req1_valid, req1_we, req1_addr, req1_be, req1_wdata} = pend[1];
    if (gen_en) bus_rdata = $urandom();
    rd_data = bus_rdata;
    if (m_busy) begin
      hit = (plan_delay != NEVER) && (m_age == int'(plan_delay));
      rd_data_valid = m_cur.we ? (noise_en && $urandom_range(0, 1) == 1) : hit;
      wr_done       = m_cur.we ? hit : (noise_en && $urandom_range(0, 1) == 1);
    end else begin
      rd_data_valid = idle_noise && $urandom_range(0, 1) == 1;
      wr_done       = idle_noise && $urandom_range(0, 1) == 1;
    end
  endtask

  // One clock: drive at posedge+1, check at posedge+4, advance model, wait for next posedge+1.
  task automatic cycle();
    logic       g, any, comp;
    logic [1:0] exp_ready, exp_done;
    logic       exp_rd, exp_wr;
    drive_inputs();
    any = pend[0].valid | pend[1].valid;
    g = (pend[0].valid && pend[1].valid) ? ~m_last : pend[1].valid;
    exp_ready = 2'b00;
    exp_done  = 2'b00;
    if (!m_busy && !m_retire && any) exp_ready[g] = 1'b1;
    if (m_retire) exp_done[m_owner] = 1'b1;
    exp_rd = m_busy && !m_cur.we;
    exp_wr = m_busy && m_cur.we;
    #3;
    chk("ready", {req1_ready, req0_ready}, exp_ready);
    chk("done", {req1_done, req0_done}, exp_done);
    chk("enables", {wr_en, rd_en}, {exp_wr, exp_rd});
    chk("timeout_flag", timeout_flag, m_tflag);
    chk("resp0", {req0_err, req0_rdata}, {m_err[0], m_rdata[0]});
    chk("resp1", {req1_err, req1_rdata}, {m_err[1], m_rdata[1]});
    if (exp_rd) chk("rd_port", {rd_be, rd_addr}, {m_cur.be, m_cur.addr});
    if (exp_wr) chk("wr_port", {wr_be, wr_addr, wr_data}, {m_cur.be, m_cur.addr, m_cur.wdata});
    if (rd_en || wr_en) begin
      obs_en++;
      if (low_run > 0 && seen_txn) chk("en_gap_ge2", low_run >= 2, 1'b1);
      seen_txn = 1;
      low_run = 0;
    end else begin
      low_run++;
    end
    if (req0_done || req1_done) begin
      obs_done  = 1;
      obs_who   = req1_done;
      obs_rdata = req1_done ? req1_rdata : req0_rdata;
      obs_err   = req1_done ? req1_err : req0_err;
    end
    if (rec_grants && (req0_ready || req1_ready)) begin
      if (grant_exp_q.size() == 0) fail("grant_unexpected");
      else chk("grant_order", req1_ready, grant_exp_q.pop_front());
    end
    // advance reference to the next clock edge
    if (m_retire) begin
      m_retire = 0;
    end else if (m_busy) begin
      comp = m_cur.we ? wr_done : rd_data_valid;
      if (comp || m_age == T - 1) begin
        m_rdata[m_owner] = comp ? rd_data : ERR_WORD;
        m_err[m_owner]   = !comp;
        if (!comp) m_tflag = 1;
        m_busy = 0;
        m_retire = 1;
      end else begin
        m_age++;
      end
    end else if (any) begin
      m_busy = 1; m_owner = g; m_cur = pend[g]; m_age = 0; m_last = g;
      txn_count++;
      if (rand_delay) plan_delay = ($urandom_range(0, 15) == 0) ? NEVER : 8'($urandom_range(0, 8));
      pend[g] = reissue[g] ? rand_req() : '0;
    end
    @(posedge M_AXI_ACLK);
    #1;
  endtask

  task automatic do_reset();
    pend[0] = '0; pend[1] = '0;
    M_AXI_ARESET = 1'b1;
    #1;
    chk("reset_enables_async", {wr_en, rd_en}, 2'b00);
    chk("reset_pulses", {req1_done, req0_done, req1_ready, req0_ready}, 4'b0);
    model_reset();
    {req0_valid, req1_valid, rd_data_valid, wr_done} = 4'b0;
    repeat (2) @(posedge M_AXI_ACLK);
    #1;
    chk("reset_state", dbg_state, 2'd0);
    chk("reset_rd_port", {rd_be, rd_addr}, 36'h0);
    chk("reset_wr_port", {wr_be, wr_addr, wr_data}, 68'h0);
    chk("reset_resp", {req1_err, req1_rdata, req0_err, req0_rdata}, 66'h0);
    chk("reset_tflag", timeout_flag, 1'b0);
    M_AXI_ARESET = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    pend[v.who] = '{valid: 1'b1, we: v.we, addr: v.addr, be: v.be, wdata: v.wdata};
    plan_delay = v.delay;
    bus_rdata  = v.resp;
    noise_en   = v.noise;
    obs_en = 0; obs_done = 0;
    for (int c = 0; c < 64 && !obs_done; c++) cycle();
    noise_en = 0;
    if (!obs_done) fail({tag, "_no_done"});
    else begin
      chk({tag, "_en_cycles"}, obs_en, v.exp_en);
      chk({tag, "_who"}, obs_who, v.who);
      chk({tag, "_rdata"}, obs_rdata, v.exp_rdata);
      chk({tag, "_err"}, obs_err, v.exp_err);
    end
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    while ((pend[0].valid || pend[1].valid || m_busy || m_retire) && c < 600) begin
      cycle();
      c++;
    end
    if (c >= 600) fail({tag, "_drain_timeout"});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h4000_0010, 4'hF, 32'h0,         8'd5,  32'h1234_5678, 1'b0, 8'd6,  32'h1234_5678, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h8000_0004, 4'h3, 32'hA5A5_0001, 8'd0,  32'h0000_0000, 1'b0, 8'd1,  32'h0000_0000, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 32'hC000_0100, 4'hF, 32'h0,         NEVER, 32'hCAFE_0000, 1'b0, 8'd20, 32'hDEAD_BEEF, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0008, 4'h1, 32'h0,         8'd19, 32'h0BAD_F00D, 1'b0, 8'd20, 32'h0BAD_F00D, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'h4000_0020, 4'hC, 32'h1122_3344, 8'd18, 32'h0000_5555, 1'b0, 8'd19, 32'h0000_5555, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h8000_0040, 4'hF, 32'h0,         8'd4,  32'h7654_3210, 1'b1, 8'd5,  32'h7654_3210, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0080, 4'hF, 32'hFFFF_0000, 8'd3,  32'h1357_2468, 1'b1, 8'd4,  32'h1357_2468, 1'b0};

    pend[0] = '0; pend[1] = '0; reissue[0] = 0; reissue[1] = 0;
    gen_en = 0; rand_delay = 0; noise_en = 0; idle_noise = 0; rec_grants = 0;
    plan_delay = 8'd2; bus_rdata = 0; txn_count = 0; obs_en = 0; obs_done = 0;
    obs_who = 0; obs_err = 0; obs_rdata = 0;
    model_reset();
    @(posedge M_AXI_ACLK);
    #1;
    do_reset();

    // single transactions, including timeout and completion-on-last-cycle
    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 4; i++) cycle();

    // strobes while nobody is in flight must not produce a done
    idle_noise = 1;
    for (int i = 0; i < 8; i++) cycle();
    idle_noise = 0;

    // simultaneous writes after reset: req0 first, then req1
    do_reset();
    pend[0] = '{valid: 1'b1, we: 1'b1, addr: 32'h4000_1000, be: 4'hF, wdata: 32'h0000_AAAA};
    pend[1] = '{valid: 1'b1, we: 1'b1, addr: 32'h8000_2000, be: 4'hF, wdata: 32'h0000_BBBB};
    plan_delay = 8'd3;
    rec_grants = 1;
    grant_exp_q.push_back(1'b0);
    grant_exp_q.push_back(1'b1);
    drain("contend");

    // both requesters always pending: strict alternation, no starvation
    for (int i = 0; i < 3; i++) begin
      grant_exp_q.push_back(1'b0);
      grant_exp_q.push_back(1'b1);
    end
    reissue[0] = 1; reissue[1] = 1;
    pend[0] = rand_req(); pend[1] = rand_req();
    for (int c = 0; c < 300 && grant_exp_q.size() != 0; c++) cycle();
    rec_grants = 0;
    reissue[0] = 0; reissue[1] = 0;
    if (grant_exp_q.size() != 0) fail("alternate_missing_grants");
    grant_exp_q.delete();
    drain("alternate");

    // randomized traffic, random latencies, stray strobes
    gen_en = 1; rand_delay = 1; noise_en = 1; idle_noise = 1;
    for (int i = 0; i < 2500; i++) cycle();
    gen_en = 0; noise_en = 0; idle_noise = 0;
    drain("random");
    rand_delay = 0;
    if (txn_count < 50) fail("random_too_few_txns");

    // reset while a read is in flight, then a normal transaction
    pend[1] = '{valid: 1'b1, we: 1'b0, addr: 32'h0000_0300, be: 4'hF, wdata: 32'h0};
    plan_delay = NEVER;
    for (int c = 0; c < 20 && !(m_busy && m_age == 3); c++) cycle();
    if (!(m_busy && m_age == 3)) fail("midreset_not_busy");
    do_reset();
    for (int i = 0; i < 5; i++) cycle();
    run_txn(vecs[0], "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // absolute guard so the run always ends
  initial begin
    #2000000;
    $display("FAIL global_time_limit");
    $fatal(1);
  end

endmodule
